weight_fetch_engine: RTL and testbench

Read-side engine for the double-buffered (ping-pong) weight SRAM that feeds the MLP processing elements. It waits until the writer marks a bank as full, then streams one layer's weights from that bank to the PE array. The stream uses a valid/ready handshake with neuron and layer boundary flags. When the layer is done it hands the bank back to the writer. It sits between the weight SRAM banks and the multiplier/adder/ReLU datapath, absorbing the 1-cycle SRAM read latency with a 2-entry skid buffer.

---
 rtl/mlp_wfetch_pkg.sv | 15 +
 rtl/wfetch_skid_fifo.sv | 46 ++++
 rtl/weight_fetch_engine.sv | 155 +++++++++++++++
 tb/tb_weight_fetch_engine.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_wfetch_pkg.sv
// Shared types and constants for the ping-pong weight fetch engine.
package mlp_wfetch_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BANK = 3'd1,
    FETCH     = 3'd2,
    DRAIN     = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int NUM_BANKS  = 2;

endpackage

// File: rtl/wfetch_skid_fifo.sv
// Two-entry skid FIFO absorbing the one-cycle SRAM read latency; payload is
// {data, last_in, last}.
module wfetch_skid_fifo
  import mlp_wfetch_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign dout   = mem[rd_ptr];

  // Storage carries no reset; only occupancy is flushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetch_engine.sv
// Streams one layer of weights from the full ping-pong SRAM bank to the PE array.
// Optional stall cycle counter enabled by WFETCH_STALL_CNT_EN.
module weight_fetch_engine
  import mlp_wfetch_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW:0]          num_in,
  input  logic [AW:0]          num_out,
  input  logic [NUM_BANKS-1:0] bank_full,
  output logic [NUM_BANKS-1:0] bank_release,
  output logic                 sram_rd_en,
  output logic                 sram_bank_sel,
  output logic [AW-1:0]        sram_rd_addr,
  input  logic [N-1:0]         sram_rd_data,
  output logic [N-1:0]         w_data,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic                 w_last_in,
  output logic                 w_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef WFETCH_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int FW = N + 2;
  localparam logic [2*AW+1:0] MAX_TOTAL = {{(AW+1){1'b0}}, 1'b1, {AW{1'b0}}};

  state_t          state, state_nxt;
  logic            cur_bank;
  logic [AW-1:0]   addr_cnt, in_cnt, out_cnt;
  logic [AW-1:0]   in_last_idx, out_last_idx;
  logic [2*AW+1:0] total;
  logic            cfg_bad, start_ok, issue, pop;
  logic            iss_last_in, iss_last;
  logic            rd_vld_p1, rd_last_in_p1, rd_last_p1;
  logic [1:0]      fifo_count;
  logic [FW-1:0]   fifo_dout;
  logic            fifo_valid;
  logic            err_q;

  assign total    = {{(AW+1){1'b0}}, num_in} * {{(AW+1){1'b0}}, num_out};
  assign cfg_bad  = (num_in == '0) || (num_out == '0) || (total > MAX_TOTAL);
  assign start_ok = (state == IDLE) && start && !cfg_bad;

  assign fifo_valid  = (fifo_count != 2'd0);
  assign pop         = fifo_valid && w_ready;
  assign iss_last_in = (in_cnt == in_last_idx);
  assign iss_last    = iss_last_in && (out_cnt == out_last_idx);
  // A same-cycle pop frees the slot the new read will land in.
  assign issue = (state == FETCH) &&
                 ((({1'b0, fifo_count} + {2'b00, rd_vld_p1}) < 3'(FIFO_DEPTH)) || pop);

  assign sram_rd_en    = issue;
  assign sram_bank_sel = cur_bank;
  assign sram_rd_addr  = addr_cnt;
  assign w_valid       = fifo_valid;
  assign w_data        = fifo_valid ? fifo_dout[FW-1:2] : '0;
  assign w_last_in     = fifo_valid && fifo_dout[1];
  assign w_last        = fifo_valid && fifo_dout[0];
  assign err           = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    bank_release = '0;
    case (state)
      IDLE:      if (start_ok) state_nxt = WAIT_BANK;
      WAIT_BANK: if (bank_full[cur_bank]) state_nxt = FETCH;
      FETCH:     if (issue && iss_last) state_nxt = DRAIN;
      DRAIN:     if (pop && fifo_dout[0]) state_nxt = RELEASE;
      RELEASE: begin
        done                   = 1'b1;
        bank_release[cur_bank] = 1'b1;
        state_nxt              = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Issue stage: address/position counters; flags follow the read as vld_p1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_bank      <= 1'b0;
      addr_cnt      <= '0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      in_last_idx   <= '0;
      out_last_idx  <= '0;
      rd_vld_p1     <= 1'b0;
      rd_last_in_p1 <= 1'b0;
      rd_last_p1    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q         <= (state == IDLE) && start && cfg_bad;
      rd_vld_p1     <= issue;
      rd_last_in_p1 <= issue && iss_last_in;
      rd_last_p1    <= issue && iss_last;
      if (start_ok) begin
        in_last_idx  <= AW'(num_in - 1'b1);
        out_last_idx <= AW'(num_out - 1'b1);
        addr_cnt     <= '0;
        in_cnt       <= '0;
        out_cnt      <= '0;
      end else if (issue) begin
        addr_cnt <= addr_cnt + 1'b1;
        if (iss_last_in) begin
          in_cnt  <= '0;
          out_cnt <= out_cnt + 1'b1;
        end else begin
          in_cnt  <= in_cnt + 1'b1;
        end
      end
      if (state == RELEASE) cur_bank <= ~cur_bank;
    end
  end

  // Return stage: read data lands in the skid FIFO one cycle after the strobe.
  wfetch_skid_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld_p1),
    .pop   (pop),
    .din   ({sram_rd_data, rd_last_in_p1, rd_last_p1}),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

`ifdef WFETCH_STALL_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      stall_cnt <= '0;
    else if (start_ok)            stall_cnt <= '0;
    else if (w_valid && !w_ready) stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_weight_fetch_engine.sv
// Self-checking bench for weight_fetch_engine with an SRAM model and a
// layer-level reference of the expected weight stream.
module tb_weight_fetch_engine;
  localparam int N  = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_in, num_out;
  logic [1:0]    bank_full;
  logic [1:0]    bank_release;
  logic          sram_rd_en, sram_bank_sel;
  logic [AW-1:0] sram_rd_addr;
  logic [N-1:0]  sram_rd_data;
  logic [N-1:0]  w_data;
  logic          w_valid, w_ready, w_last_in, w_last;
  logic          busy, done, err;
`ifdef WFETCH_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_bank = 0;
  logic [N-1:0] mem [2][256];

  weight_fetch_engine #(.N(N), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_in        (num_in),
    .num_out       (num_out),
    .bank_full     (bank_full),
    .bank_release  (bank_release),
    .sram_rd_en    (sram_rd_en),
    .sram_bank_sel (sram_bank_sel),
    .sram_rd_addr  (sram_rd_addr),
    .sram_rd_data  (sram_rd_data),
    .w_data        (w_data),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_last_in     (w_last_in),
    .w_last        (w_last),
    .busy          (busy),
    .done          (done),
    .err           (err)
`ifdef WFETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rd_data <= mem[sram_bank_sel][sram_rd_addr];
  end

  // Runs one layer and compares the stream against the layer description.
  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic stream_layer(input int ni, input int no, input int mode,
                              input int raise_at, input bit chain);
    int total, nrd, nacc, first_rd, first_vld, last_acc, stalls, occ, exp_rd;
    bit rd_prev, held_v, fin;
    logic [N-1:0] held, ed;
    logic eli, el;
    logic [1:0] exp_rel;
    total = ni * no;
    nrd = 0; nacc = 0; first_rd = -1; first_vld = -1; last_acc = -1;
    stalls = 0; rd_prev = 0; held_v = 0; fin = 0; held = '0;
    exp_rel = (exp_bank == 0) ? 2'b01 : 2'b10;
    exp_rd = (raise_at >= 0) ? raise_at + 1 : 2;
    for (int c = 0; c < 4 * total + 40 && !fin; c++) begin
      if (!(chain && c == 0)) @(negedge clk);
      start   = (c == 0);
      num_in  = 9'(ni);
      num_out = 9'(no);
      if (c == raise_at) bank_full = exp_rel;
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = (c % 4 == 0) || (c % 4 == 3);
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      occ = (nrd - (rd_prev ? 1 : 0)) - nacc;
      checks++;
      if (occ > 2 || w_valid !== (occ > 0)) begin
        errors++;
        $display("FAIL occupancy c=%0d: w_valid=%b buffered=%0d, required w_valid=%b and buffered<=2",
                 c, w_valid, occ, (occ > 0));
      end
      if (first_vld < 0 && w_valid === 1'b1) first_vld = c;
      if (held_v) begin
        checks++;
        if (w_valid !== 1'b1 || w_data !== held) begin
          errors++;
          $display("FAIL hold c=%0d: w_valid=%b w_data=%h, required 1 %h", c, w_valid, w_data, held);
        end
      end
      rd_prev = sram_rd_en;
      if (sram_rd_en === 1'b1) begin
        if (first_rd < 0) first_rd = c;
        checks++;
        if (sram_bank_sel !== 1'(exp_bank) || sram_rd_addr !== 8'(nrd) || nrd >= total) begin
          errors++;
          $display("FAIL read_addr c=%0d: bank=%0d addr=%0d, required bank=%0d addr=%0d (<%0d)",
                   c, sram_bank_sel, sram_rd_addr, exp_bank, nrd, total);
        end
        nrd++;
      end
      if (w_valid && w_ready) begin
        ed  = mem[exp_bank][nacc % 256];
        eli = ((nacc % ni) == ni - 1);
        el  = (nacc == total - 1);
        checks++;
        if (nacc >= total || w_data !== ed || w_last_in !== eli || w_last !== el) begin
          errors++;
          $display("FAIL word %0d: data=%h last_in=%b last=%b, required %h %b %b",
                   nacc, w_data, w_last_in, w_last, ed, eli, el);
        end
        if (mode == 0) begin
          checks++;
          if (c != first_vld + nacc) begin
            errors++;
            $display("FAIL rate word %0d: accepted at cycle %0d, required %0d", nacc, c, first_vld + nacc);
          end
        end
        if (el) last_acc = c;
        nacc++;
      end
      held_v = w_valid && !w_ready;
      held   = w_data;
      if (held_v) stalls++;
      if ((last_acc >= 0 && c == last_acc + 1) || done === 1'b1 || bank_release !== 2'b00) begin
        checks++;
        if (last_acc < 0 || c != last_acc + 1 || done !== 1'b1 || bank_release !== exp_rel) begin
          errors++;
          $display("FAIL release c=%0d: done=%b bank_release=%b, required done=1 rel=%b at cycle %0d",
                   c, done, bank_release, exp_rel, last_acc + 1);
        end
      end
      if (last_acc >= 0 && c == last_acc + 2) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bank_release !== 2'b00) begin
          errors++;
          $display("FAIL idle_after c=%0d: busy=%b done=%b rel=%b, required 0 0 00", c, busy, done, bank_release);
        end
        fin = 1;
      end
    end
    start = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL timeout: accepted %0d words, required %0d", nacc, total);
    end
    checks++;
    if (first_rd != exp_rd || first_vld != exp_rd + 2) begin
      errors++;
      $display("FAIL latency: first rd_en cycle %0d first w_valid cycle %0d, required %0d %0d",
               first_rd, first_vld, exp_rd, exp_rd + 2);
    end
    checks++;
    if (nacc != total || nrd != total) begin
      errors++;
      $display("FAIL counts: reads=%0d accepts=%0d, required %0d", nrd, nacc, total);
    end
`ifdef WFETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'(stalls)) begin
      errors++;
      $display("FAIL stall_cnt: got %0d, required %0d", stall_cnt, stalls);
    end
`endif
    exp_bank ^= 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_in = '0; num_out = '0; bank_full = 2'b00; w_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bank_release !== 2'b00 || sram_rd_en !== 1'b0 || sram_bank_sel !== 1'b0 || sram_rd_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_sram: rel=%b rd_en=%b sel=%b addr=%0d, required all 0",
               bank_release, sram_rd_en, sram_bank_sel, sram_rd_addr);
    end
    checks++;
    if (w_data !== '0 || w_valid !== 1'b0 || w_last_in !== 1'b0 || w_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_stream: data=%h valid=%b last_in=%b last=%b, required all 0",
               w_data, w_valid, w_last_in, w_last);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b err=%b, required 0 0 0", busy, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_bank = 0;
  endtask

  task automatic test_basic();
    bank_full = 2'b01;
    stream_layer(3, 2, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    bank_full = 2'b11;
    stream_layer(3, 2, 1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int ni1, no1, ni2, no2;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 256; k++) mem[b][k] = 16'($urandom);
    ni1 = $urandom_range(1, 16); no1 = $urandom_range(1, 16);
    ni2 = $urandom_range(1, 16); no2 = $urandom_range(1, 16);
    bank_full = 2'b11;
    stream_layer(ni1, no1, 2, -1, 1'b0);
    stream_layer(ni2, no2, 2, -1, 1'b1);
  endtask

  task automatic test_bank_wait();
    bank_full = 2'b00;
    stream_layer(4, 3, 0, 10, 1'b0);
  endtask

  task automatic test_max_layer();
    bank_full = 2'b11;
    stream_layer(256, 1, 0, -1, 1'b0);
  endtask

  task automatic bad_cfg(input int ni, input int no);
    int nerr;
    bit seen_busy, seen_rd;
    nerr = 0; seen_busy = 0; seen_rd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start   = (c == 0);
      num_in  = 9'(ni);
      num_out = 9'(no);
      w_ready = 1'b1;
      #1;
      if (err === 1'b1) nerr++;
      if (busy !== 1'b0) seen_busy = 1;
      if (sram_rd_en !== 1'b0) seen_rd = 1;
    end
    start = 1'b0;
    checks++;
    if (nerr != 1) begin
      errors++;
      $display("FAIL err_pulse %0dx%0d: err high %0d cycles, required 1", ni, no, nerr);
    end
    checks++;
    if (seen_busy || seen_rd) begin
      errors++;
      $display("FAIL err_idle %0dx%0d: busy_seen=%b rd_seen=%b, required 0 0", ni, no, seen_busy, seen_rd);
    end
  endtask

  task automatic test_bad_config();
    bank_full = 2'b11;
    bad_cfg(17, 16);
    bad_cfg(0, 4);
    bad_cfg(4, 0);
  endtask

  task automatic test_reset_mid();
    int acc;
    bank_full = 2'b11;
    acc = 0;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      @(negedge clk);
      start   = (c == 0);
      num_in  = 9'd4;
      num_out = 9'd4;
      w_ready = 1'b1;
      #1;
      checks++;
      if (bank_release !== 2'b00) begin
        errors++;
        $display("FAIL early_release c=%0d: rel=%b, required 00", c, bank_release);
      end
      if (w_valid && w_ready) acc++;
    end
    start = 1'b0;
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL mid_progress: accepted %0d, required 4", acc);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || w_valid !== 1'b0 || sram_rd_en !== 1'b0 || sram_rd_addr !== 8'd0 ||
        w_data !== '0 || bank_release !== 2'b00 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b rd=%b addr=%0d data=%h rel=%b done=%b, required all 0",
               busy, w_valid, sram_rd_en, sram_rd_addr, w_data, bank_release, done);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bank_release !== 2'b00 || sram_bank_sel !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: busy=%b rel=%b sel=%b, required 0 00 0", busy, bank_release, sram_bank_sel);
    end
    exp_bank = 0;
    stream_layer(5, 3, 2, -1, 1'b0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 256; k++) mem[b][k] = 16'(k + 1);
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_bank_wait();
    test_max_layer();
    test_bad_config();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
